ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, ALU result and store data.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5: register-file address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports ex_valid (in, 1), ex_pc (in, DATA_WIDTH), ex_imm (in, DATA_WIDTH), ex_alu_result (in, DATA_WIDTH; ALU output, compare ops give 0/1), ex_rs2_data (in, DATA_WIDTH), ex_rd (in, REG_ADDR_WIDTH), ex_funct3 (in, 3).
REQ-006 SHALL have control inputs, each 1 bit: ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr, stall, flush.
REQ-007 SHALL have registered outputs mem_valid (1), mem_alu_result, mem_wdata, mem_pc_plus4 (DATA_WIDTH each), mem_rd (REG_ADDR_WIDTH), mem_funct3 (3), mem_reg_write, mem_mem_read, mem_mem_write, mem_link (1 each).
REQ-008 SHALL have registered outputs redirect (1, one-cycle pulse) and redirect_pc (DATA_WIDTH).

Function
REQ-009 Capture: on a clock edge with stall=0 and flush=0, all mem_* registers SHALL load the corresponding ex_* values; mem_pc_plus4 <= ex_pc+4; mem_link <= ex_jal|ex_jalr. Latency is one cycle.
REQ-010 Effective valid SHALL be v = ex_valid & (state==RUN); mem_valid <= v; if v=0, mem_reg_write, mem_mem_read, mem_mem_write and mem_link SHALL be loaded 0 (data fields don't-care).
REQ-011 Taken SHALL be t = v & (ex_jal | ex_jalr | (ex_branch & ex_alu_result[0])).
REQ-012 Target SHALL be ex_pc+ex_imm for branch/JAL, and {ex_alu_result[DATA_WIDTH-1:1],1'b0} for JALR; all sums modulo 2^DATA_WIDTH (wrap silently).
REQ-013 On a capture edge redirect <= t and redirect_pc <= target (redirect_pc holds its value when t=0); redirect SHALL be 0 on every edge that is not a capture edge.
REQ-014 FSM states RUN, SQUASH: RUN->SQUASH on capture with t=1; SQUASH->RUN on any capture edge (the squashed wrong-path instruction is dropped per REQ-010); otherwise hold.
REQ-015 Stall (stall=1, flush=0): all registers and state SHALL hold, except redirect, which SHALL go 0.
REQ-016 Flush (flush=1, any stall): mem_valid and all mem_* enables <= 0, redirect <= 0, state <= RUN; flush SHALL win over stall and over a simultaneous taken branch.
REQ-017 Back-to-back taken branches SHALL NOT produce two consecutive redirect pulses; the second is squashed.

Reset
REQ-018 While reset=1, all outputs SHALL be 0 (mem_valid, enables, redirect, all data fields, redirect_pc) and state SHALL be RUN, independent of clk.
REQ-019 Reset asserted mid-stall or in SQUASH SHALL discard the pending squash; the first edge after deassertion behaves as REQ-009.

Configuration
REQ-020 With macro EX_MEM_PERF_EN defined, SHALL add outputs perf_retired (32) and perf_redirects (32): +1 per capture edge with v=1 and per capture edge with t=1 respectively, wrapping at 2^32, zeroed by reset, held on stall/flush edges.
REQ-021 Without EX_MEM_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-022 Package ex_mem_pkg SHALL hold the state enum (RUN, SQUASH), the ex/mem control-bundle struct (reg_write, mem_read, mem_write, link), and the PC increment constant 4.
REQ-023 Taken/target logic (REQ-011, REQ-012) SHALL be a combinational sub-module branch_resolve; the sequential logic remains in ex_mem_stage.

Verification
REQ-024 Reset then ex_valid=1, ex_alu_result=0x0000_00A5, ex_rd=7, ex_reg_write=1 -> next edge mem_valid=1, mem_alu_result=0xA5, mem_rd=7, redirect=0.
REQ-025 BEQ ex_pc=0x100, ex_imm=0x20, ex_branch=1, ex_alu_result=1 -> redirect=1, redirect_pc=0x120 for one cycle; next instruction with ex_valid=1, ex_reg_write=1 -> mem_valid=0, mem_reg_write=0; the one after -> mem_valid=1.
REQ-026 Same branch with ex_alu_result=0 -> redirect=0, state stays RUN; JALR with ex_alu_result=0x203 -> redirect_pc=0x202, mem_link=1, mem_pc_plus4=ex_pc+4.
REQ-027 Taken branch with stall=1 on the SQUASH cycle for 3 cycles -> outputs hold, redirect=0 after its first cycle, squash applied to the first non-stalled capture; flush=1 together with stall=1 -> mem_valid=0, state RUN.
REQ-028 ex_pc=0xFFFF_FFF0, ex_imm=0x20, JAL -> redirect_pc=0x0000_0010; assert reset asynchronously mid-cycle -> all outputs 0 before the next edge; with EX_MEM_PERF_EN, 5 valid captures including 2 taken -> perf_retired=5, perf_redirects=2.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register stage.
package ex_mem_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic link;
  } ctrl_t;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch/jump resolution: decides whether control flow is redirected
// and where to. Sums wrap modulo 2^DATA_WIDTH.
module branch_resolve #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  branch,
  input  logic                  jal,
  input  logic                  jalr,
  output logic                  taken,
  output logic [DATA_WIDTH-1:0] target
);

  // Compare ops leave their outcome in alu_result[0].
  assign taken  = valid & (jal | jalr | (branch & alu_result[0]));
  assign target = jalr ? {alu_result[DATA_WIDTH-1:1], 1'b0} : pc + imm;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect and one-slot wrong-path squash.
// Optional performance counters are enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     ex_pc,
  input  logic [DATA_WIDTH-1:0]     ex_imm,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [2:0]                ex_funct3,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_branch,
  input  logic                      ex_jal,
  input  logic                      ex_jalr,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      mem_valid,
  output logic [DATA_WIDTH-1:0]     mem_alu_result,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH-1:0]     mem_pc_plus4,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [2:0]                mem_funct3,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      mem_link,
  output logic                      redirect,
  output logic [DATA_WIDTH-1:0]     redirect_pc
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]               perf_retired,
  output logic [31:0]               perf_redirects
`endif
);

  state_t                state_reg, state_next;
  ctrl_t                 ctrl_reg, ctrl_next;
  logic                  v;
  logic                  taken;
  logic [DATA_WIDTH-1:0] target;

  // An instruction arriving while in SQUASH is the wrong-path slot and is dropped.
  assign v = ex_valid & (state_reg == RUN);

  branch_resolve #(.DATA_WIDTH(DATA_WIDTH)) u_branch_resolve (
    .valid      (v),
    .pc         (ex_pc),
    .imm        (ex_imm),
    .alu_result (ex_alu_result),
    .branch     (ex_branch),
    .jal        (ex_jal),
    .jalr       (ex_jalr),
    .taken      (taken),
    .target     (target)
  );

  always_comb begin
    state_next = state_reg;
    ctrl_next  = '0;
    if (flush) begin
      state_next = RUN;
    end else if (!stall) begin
      state_next = taken ? SQUASH : RUN;
    end
    ctrl_next.reg_write = v & ex_reg_write;
    ctrl_next.mem_read  = v & ex_mem_read;
    ctrl_next.mem_write = v & ex_mem_write;
    ctrl_next.link      = v & (ex_jal | ex_jalr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RUN;
      ctrl_reg       <= '0;
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_wdata      <= '0;
      mem_pc_plus4   <= '0;
      mem_rd         <= '0;
      mem_funct3     <= '0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
`ifdef EX_MEM_PERF_EN
      perf_retired   <= '0;
      perf_redirects <= '0;
`endif
    end else begin
      state_reg <= state_next;
      redirect  <= 1'b0;
      if (flush) begin
        mem_valid <= 1'b0;
        ctrl_reg  <= '0;
      end else if (!stall) begin
        mem_valid      <= v;
        ctrl_reg       <= ctrl_next;
        mem_alu_result <= ex_alu_result;
        mem_wdata      <= ex_rs2_data;
        mem_pc_plus4   <= ex_pc + DATA_WIDTH'(PC_INCR);
        mem_rd         <= ex_rd;
        mem_funct3     <= ex_funct3;
        redirect       <= taken;
        if (taken) redirect_pc <= target;
`ifdef EX_MEM_PERF_EN
        if (v)     perf_retired   <= perf_retired + 32'd1;
        if (taken) perf_redirects <= perf_redirects + 32'd1;
`endif
      end
    end
  end

  assign mem_reg_write = ctrl_reg.reg_write;
  assign mem_mem_read  = ctrl_reg.mem_read;
  assign mem_mem_write = ctrl_reg.mem_write;
  assign mem_link      = ctrl_reg.link;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; define EX_MEM_PERF_EN to also
// exercise the performance counters.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_alu_result, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr;
  logic        stall, flush;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_wdata, mem_pc_plus4;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_link;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_retired, perf_redirects;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_wdata(mem_wdata),
    .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_link(mem_link),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef EX_MEM_PERF_EN
    , .perf_retired(perf_retired), .perf_redirects(perf_redirects)
`endif
  );

  // Stimulus helpers: apply an instruction / advance one edge (sample 1ns after it).
  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                        input logic br, input logic jal, input logic jalr);
    ex_valid = v; ex_pc = pc; ex_imm = imm; ex_alu_result = alu;
    ex_rs2_data = 32'h0; ex_rd = rd; ex_funct3 = 3'd0;
    ex_reg_write = rw; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_branch = br; ex_jal = jal; ex_jalr = jalr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0t st=%b fl=%b mem_valid=%b rd=%0d alu=%h redirect=%b rpc=%h",
             $time, stall, flush, mem_valid, mem_rd, mem_alu_result, redirect, redirect_pc);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 32'h10, 32'h4, 32'h55, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", mem_valid); end
    total++; if ({mem_reg_write, mem_mem_read, mem_mem_write, mem_link} !== 4'b0) begin bad++; $display("FAIL reset_enables got=%b exp=0000", {mem_reg_write, mem_mem_read, mem_mem_write, mem_link}); end
    total++; if ({mem_alu_result, mem_wdata, mem_pc_plus4, redirect_pc} !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {mem_alu_result, mem_wdata, mem_pc_plus4, redirect_pc}); end
    total++; if ({redirect, mem_rd, mem_funct3} !== 9'h0) begin bad++; $display("FAIL reset_misc got=%h exp=0", {redirect, mem_rd, mem_funct3}); end
    reset = 1'b0;
  endtask

  task automatic test_capture();
    set_ex(1'b1, 32'h40, 32'h0, 32'h0000_00A5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_rs2_data = 32'h1234_5678; ex_funct3 = 3'd2; ex_mem_read = 1'b1;
    tick();
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%b exp=1", mem_valid); end
    total++; if (mem_alu_result !== 32'hA5) begin bad++; $display("FAIL cap_alu got=%h exp=000000a5", mem_alu_result); end
    total++; if (mem_rd !== 5'd7) begin bad++; $display("FAIL cap_rd got=%0d exp=7", mem_rd); end
    total++; if ({mem_reg_write, mem_mem_read, mem_mem_write, mem_link} !== 4'b1100) begin bad++; $display("FAIL cap_enables got=%b exp=1100", {mem_reg_write, mem_mem_read, mem_mem_write, mem_link}); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL cap_redirect got=%b exp=0", redirect); end
    total++; if (mem_pc_plus4 !== 32'h44) begin bad++; $display("FAIL cap_pc4 got=%h exp=00000044", mem_pc_plus4); end
    total++; if (mem_wdata !== 32'h1234_5678 || mem_funct3 !== 3'd2) begin bad++; $display("FAIL cap_wdata got=%h/%0d exp=12345678/2", mem_wdata, mem_funct3); end
  endtask

  task automatic test_branch_taken();
    set_ex(1'b1, 32'h100, 32'h20, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin bad++; $display("FAIL beq_redirect got=%b/%h exp=1/00000120", redirect, redirect_pc); end
    set_ex(1'b1, 32'h104, 32'h0, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0) begin bad++; $display("FAIL beq_squash got=%b/%b exp=0/0", mem_valid, mem_reg_write); end
    total++; if (redirect !== 1'b0 || redirect_pc !== 32'h120) begin bad++; $display("FAIL beq_pulse got=%b/%h exp=0/00000120", redirect, redirect_pc); end
    set_ex(1'b1, 32'h120, 32'h0, 32'h6, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b1 || mem_reg_write !== 1'b1 || mem_rd !== 5'd4) begin bad++; $display("FAIL beq_resume got=%b/%b/%0d exp=1/1/4", mem_valid, mem_reg_write, mem_rd); end
  endtask

  task automatic test_not_taken_jalr();
    set_ex(1'b1, 32'h100, 32'h20, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (redirect !== 1'b0 || mem_valid !== 1'b1) begin bad++; $display("FAIL bne_taken got=%b/%b exp=0/1", redirect, mem_valid); end
    set_ex(1'b1, 32'h104, 32'h0, 32'h9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd5) begin bad++; $display("FAIL bne_run got=%b/%0d exp=1/5", mem_valid, mem_rd); end
    set_ex(1'b1, 32'h300, 32'h0, 32'h203, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h202) begin bad++; $display("FAIL jalr_target got=%b/%h exp=1/00000202", redirect, redirect_pc); end
    total++; if (mem_link !== 1'b1 || mem_pc_plus4 !== 32'h304) begin bad++; $display("FAIL jalr_link got=%b/%h exp=1/00000304", mem_link, mem_pc_plus4); end
    set_ex(1'b1, 32'h304, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b0 || mem_link !== 1'b0) begin bad++; $display("FAIL jalr_squash got=%b/%b exp=0/0", mem_valid, mem_link); end
  endtask

  task automatic test_stall_squash();
    set_ex(1'b1, 32'h500, 32'h10, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h510) begin bad++; $display("FAIL stall_br got=%b/%h exp=1/00000510", redirect, redirect_pc); end
    set_ex(1'b1, 32'h504, 32'h0, 32'h77, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'h1 || mem_rd !== 5'd0 || redirect !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%0d/%b exp=1/00000001/0/0", i, mem_valid, mem_alu_result, mem_rd, redirect); end
    end
    stall = 1'b0;
    tick();
    total++; if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || mem_alu_result !== 32'h77) begin bad++; $display("FAIL stall_squash got=%b/%b/%h exp=0/0/00000077", mem_valid, mem_reg_write, mem_alu_result); end
    set_ex(1'b1, 32'h510, 32'h0, 32'h78, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd10) begin bad++; $display("FAIL stall_resume got=%b/%0d exp=1/10", mem_valid, mem_rd); end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 32'h600, 32'h40, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h640) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/00000640", redirect, redirect_pc); end
    set_ex(1'b1, 32'h604, 32'h80, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (redirect !== 1'b0 || mem_valid !== 1'b0 || redirect_pc !== 32'h640) begin bad++; $display("FAIL b2b_second got=%b/%b/%h exp=0/0/00000640", redirect, mem_valid, redirect_pc); end
    set_ex(1'b1, 32'h640, 32'h0, 32'h3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b1 || redirect !== 1'b0) begin bad++; $display("FAIL b2b_resume got=%b/%b exp=1/0", mem_valid, redirect); end
  endtask

  task automatic test_flush();
    set_ex(1'b1, 32'h700, 32'h8, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 32'h704, 32'h0, 32'h11, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick();
    total++; if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || redirect !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b/%b/%b exp=0/0/0", mem_valid, mem_reg_write, redirect); end
    stall = 1'b0; flush = 1'b0;
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd11) begin bad++; $display("FAIL flush_run got=%b/%0d exp=1/11", mem_valid, mem_rd); end
    set_ex(1'b1, 32'h800, 32'h8, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    total++; if (redirect !== 1'b0 || mem_valid !== 1'b0 || mem_link !== 1'b0) begin bad++; $display("FAIL flush_taken got=%b/%b/%b exp=0/0/0", redirect, mem_valid, mem_link); end
    flush = 1'b0;
    set_ex(1'b1, 32'h900, 32'h0, 32'h12, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd12) begin bad++; $display("FAIL flush_after got=%b/%0d exp=1/12", mem_valid, mem_rd); end
  endtask

  task automatic test_jal_wrap_async_reset();
    set_ex(1'b1, 32'hFFFF_FFF0, 32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h10) begin bad++; $display("FAIL jal_wrap got=%b/%h exp=1/00000010", redirect, redirect_pc); end
    total++; if (mem_link !== 1'b1 || mem_pc_plus4 !== 32'hFFFF_FFF4) begin bad++; $display("FAIL jal_link got=%b/%h exp=1/fffffff4", mem_link, mem_pc_plus4); end
    // Now in SQUASH; hold it with stall, then reset asynchronously between edges.
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    total++; if ({mem_valid, mem_reg_write, mem_link, redirect} !== 4'b0 || redirect_pc !== 32'h0 || mem_pc_plus4 !== 32'h0) begin bad++; $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", {mem_valid, mem_reg_write, mem_link, redirect}, redirect_pc, mem_pc_plus4); end
    #2;
    reset = 1'b0; stall = 1'b0;
    set_ex(1'b1, 32'hA00, 32'h0, 32'h21, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd13 || mem_alu_result !== 32'h21) begin bad++; $display("FAIL reset_unsquash got=%b/%0d/%h exp=1/13/00000021", mem_valid, mem_rd, mem_alu_result); end
  endtask

`ifdef EX_MEM_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (perf_retired !== 32'd0 || perf_redirects !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_retired, perf_redirects); end
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 32'h0, 32'h0, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      set_ex(1'b1, 32'h4, 32'h10, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      set_ex(1'b1, 32'h8, 32'h0, 32'h1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    stall = 1'b1; tick(); stall = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    set_ex(1'b1, 32'h20, 32'h0, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    total++; if (perf_retired !== 32'd5 || perf_redirects !== 32'd2) begin bad++; $display("FAIL perf_counts got=%0d/%0d exp=5/2", perf_retired, perf_redirects); end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_branch_taken();
    test_not_taken_jalr();
    test_stall_squash();
    test_back_to_back();
    test_flush();
    test_jal_wrap_async_reset();
`ifdef EX_MEM_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
